// File: rtl/pipe_pkg.sv
// Shared definitions for the hazard scoreboard: entry layout, forward-select
// encoding, control decision type and a constant clog2 helper.
package pipe_pkg;

  // Entry field offsets; register-address fields follow the flag bits.
  localparam int unsigned F_V  = 0;
  localparam int unsigned F_WE = 1;
  localparam int unsigned F_LD = 2;
  localparam int unsigned F_RD = 3;

  // Forward-select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

  typedef enum logic [1:0] {
    CTL_RUN,
    CTL_MEMWAIT,
    CTL_HAZARD,
    CTL_REDIRECT
  } ctl_e;

  function automatic int unsigned f_rs(input int unsigned raw);
    return F_RD + raw;
  endfunction

  function automatic int unsigned f_rt(input int unsigned raw);
    return F_RD + 2 * raw;
  endfunction

  function automatic int unsigned ent_w(input int unsigned raw);
    return F_RD + 3 * raw;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Nearest-producer priority encoder: returns the lowest stage index whose
// active destination equals src, or 0 when nothing matches or src is r0.
module hz_match #(
  parameter int unsigned NSTG = 3,
  parameter int unsigned RAW  = 5,
  parameter int unsigned FSW  = 2
) (
  input  logic [RAW-1:0]      src,
  input  logic [NSTG:1]       act,
  input  logic [NSTG*RAW-1:0] rd,
  output logic [FSW-1:0]      idx
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    idx = '0;
    for (int unsigned k = NSTG; k >= 1; k--)
      if (act[k] && (src != '0) && (rd[(k-1)*RAW +: RAW] == src))
        idx = FSW'(k);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight writers after decode, produces
// stall/flush controls, operand forward selects and performance counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NSTG  = 3,
  parameter int unsigned RAW   = 5,
  parameter int unsigned LDSTG = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IssueD,
  input  logic [RAW-1:0]               RsD,
  input  logic [RAW-1:0]               RtD,
  input  logic                         UseRsD,
  input  logic                         UseRtD,
  input  logic                         BranchD,
  input  logic                         WeD,
  input  logic                         LoadD,
  input  logic [RAW-1:0]               RdD,
  input  logic                         TakenD,
  input  logic                         MemBusy,
  input  logic                         ClrCnt,
  output logic                         StallF,
  output logic                         FlushD,
  output logic                         FlushE,
  output logic [clog2(NSTG+1)-1:0]     FwdAD,
  output logic [clog2(NSTG+1)-1:0]     FwdBD,
  output logic [clog2(NSTG+1)-1:0]     FwdAE,
  output logic [clog2(NSTG+1)-1:0]     FwdBE,
  output logic [CNTW-1:0]              StallCnt,
  output logic [CNTW-1:0]              FlushCnt
);

  localparam int unsigned FSW = clog2(NSTG + 1);
  localparam int unsigned EW  = ent_w(RAW);
  localparam int unsigned RSO = f_rs(RAW);
  localparam int unsigned RTO = f_rt(RAW);

  logic [EW-1:0]       ent [1:NSTG];
  logic [EW-1:0]       dec_ent;
  logic [NSTG:1]       act, act_e, ldv;
  logic [NSTG*RAW-1:0] rdv;
  logic [FSW-1:0]      idx_ad, idx_bd, idx_ae, idx_be;
  logic                ld_a, ld_b, hz_stall;
  ctl_e                ctl;

  function automatic logic src_hazard(input logic used, input logic br,
                                      input logic [FSW-1:0] idx, input logic ld);
    if (!used || idx == '0) return 1'b0;
    if (br) return (idx == FSW'(1)) || (ld && (32'(idx) < LDSTG));
    return ld && (32'(idx) + 1 < LDSTG);
  endfunction

  // Flatten the entry array into match vectors; E-side search skips entry 1.
  always_comb begin
    act = '0;
    ldv = '0;
    rdv = '0;
    for (int unsigned k = 1; k <= NSTG; k++) begin
      act[k] = ent[k][F_V] & ent[k][F_WE];
      ldv[k] = ent[k][F_LD];
      rdv[(k-1)*RAW +: RAW] = ent[k][F_RD +: RAW];
    end
    act_e    = act;
    act_e[1] = 1'b0;
  end

  hz_match #(.NSTG(NSTG), .RAW(RAW), .FSW(FSW)) u_match_ad (
    .src(RsD), .act(act), .rd(rdv), .idx(idx_ad)
  );
  hz_match #(.NSTG(NSTG), .RAW(RAW), .FSW(FSW)) u_match_bd (
    .src(RtD), .act(act), .rd(rdv), .idx(idx_bd)
  );
  hz_match #(.NSTG(NSTG), .RAW(RAW), .FSW(FSW)) u_match_ae (
    .src(ent[1][RSO +: RAW]), .act(act_e), .rd(rdv), .idx(idx_ae)
  );
  hz_match #(.NSTG(NSTG), .RAW(RAW), .FSW(FSW)) u_match_be (
    .src(ent[1][RTO +: RAW]), .act(act_e), .rd(rdv), .idx(idx_be)
  );

  // Load flag of each decode source's nearest producer, and the stall decision.
  // Decode sources search from entry 1; when a branch does not stall, the
  // nearest match cannot be entry 1, so the same index serves as forward select.
  always_comb begin
    ld_a = 1'b0;
    ld_b = 1'b0;
    for (int unsigned k = 1; k <= NSTG; k++) begin
      if (idx_ad == FSW'(k)) ld_a = ldv[k];
      if (idx_bd == FSW'(k)) ld_b = ldv[k];
    end
    hz_stall = src_hazard(UseRsD, BranchD, idx_ad, ld_a) |
               src_hazard(UseRtD, BranchD, idx_bd, ld_b);
  end

  // Forward selects for decode-stage compares and the E-stage operands.
  always_comb begin
    FwdAD = FSW'(FWD_RF);
    FwdBD = FSW'(FWD_RF);
    FwdAE = FSW'(FWD_RF);
    FwdBE = FSW'(FWD_RF);
    if (BranchD && !hz_stall) begin
      FwdAD = idx_ad;
      FwdBD = idx_bd;
    end
    if (ent[1][F_V]) begin
      FwdAE = idx_ae;
      FwdBE = idx_be;
    end
  end

  // Pipe control: memory wait beats hazard stall, which beats redirect.
  always_comb begin
    if (MemBusy)       ctl = CTL_MEMWAIT;
    else if (hz_stall) ctl = CTL_HAZARD;
    else if (TakenD)   ctl = CTL_REDIRECT;
    else               ctl = CTL_RUN;
    StallF = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    case (ctl)
      CTL_MEMWAIT:  StallF = 1'b1;
      CTL_HAZARD: begin
        StallF = 1'b1;
        FlushE = 1'b1;
      end
      CTL_REDIRECT: FlushD = 1'b1;
      default: ;
    endcase
  end

  // Pack the decode instruction into entry layout.
  always_comb begin
    dec_ent             = '0;
    dec_ent[F_V]        = 1'b1;
    dec_ent[F_WE]       = WeD;
    dec_ent[F_LD]       = LoadD;
    dec_ent[F_RD +: RAW] = RdD;
    dec_ent[RSO +: RAW] = RsD;
    dec_ent[RTO +: RAW] = RtD;
  end

  // Entry shift register; frozen while memory is busy, bubble on stall/no issue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 1; k <= NSTG; k++) ent[k] <= '0;
    end else if (!MemBusy) begin
      ent[1] <= (IssueD && !hz_stall) ? dec_ent : '0;
      for (int unsigned k = 2; k <= NSTG; k++) ent[k] <= ent[k-1];
    end
  end

  // Saturating performance counters with synchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (ClrCnt) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1))            StallCnt <= StallCnt + CNTW'(1);
      if ((FlushD || FlushE) && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a vector table on the default
// configuration plus directed sequences on a deep, narrow-counter instance.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Instance A: NSTG=3, LDSTG=2, CNTW=16
  logic       a_rst = 1'b0, a_issue = 1'b0, a_urs = 1'b0, a_urt = 1'b0, a_br = 1'b0;
  logic       a_we = 1'b0, a_ld = 1'b0, a_tk = 1'b0, a_mb = 1'b0, a_clr = 1'b0;
  logic [4:0] a_rs = '0, a_rt = '0, a_rd = '0;
  logic       a_stall, a_fld, a_fle;
  logic [1:0] a_fad, a_fbd, a_fae, a_fbe;
  logic [15:0] a_scnt, a_fcnt;

  // Instance B: NSTG=5, LDSTG=4, CNTW=2
  logic       b_rst = 1'b0, b_issue = 1'b0, b_urs = 1'b0, b_urt = 1'b0, b_br = 1'b0;
  logic       b_we = 1'b0, b_ld = 1'b0, b_tk = 1'b0, b_mb = 1'b0, b_clr = 1'b0;
  logic [4:0] b_rs = '0, b_rt = '0, b_rd = '0;
  logic       b_stall, b_fld, b_fle;
  logic [2:0] b_fad, b_fbd, b_fae, b_fbe;
  logic [1:0] b_scnt, b_fcnt;

  hazard_scoreboard #(.NSTG(3), .RAW(5), .LDSTG(2), .CNTW(16)) dut_a (
    .CLK(clk), .RST(a_rst), .IssueD(a_issue), .RsD(a_rs), .RtD(a_rt),
    .UseRsD(a_urs), .UseRtD(a_urt), .BranchD(a_br), .WeD(a_we), .LoadD(a_ld),
    .RdD(a_rd), .TakenD(a_tk), .MemBusy(a_mb), .ClrCnt(a_clr),
    .StallF(a_stall), .FlushD(a_fld), .FlushE(a_fle),
    .FwdAD(a_fad), .FwdBD(a_fbd), .FwdAE(a_fae), .FwdBE(a_fbe),
    .StallCnt(a_scnt), .FlushCnt(a_fcnt)
  );

  hazard_scoreboard #(.NSTG(5), .RAW(5), .LDSTG(4), .CNTW(2)) dut_b (
    .CLK(clk), .RST(b_rst), .IssueD(b_issue), .RsD(b_rs), .RtD(b_rt),
    .UseRsD(b_urs), .UseRtD(b_urt), .BranchD(b_br), .WeD(b_we), .LoadD(b_ld),
    .RdD(b_rd), .TakenD(b_tk), .MemBusy(b_mb), .ClrCnt(b_clr),
    .StallF(b_stall), .FlushD(b_fld), .FlushE(b_fle),
    .FwdAD(b_fad), .FwdBD(b_fbd), .FwdAE(b_fae), .FwdBE(b_fbe),
    .StallCnt(b_scnt), .FlushCnt(b_fcnt)
  );

  typedef struct {
    logic       issue, urs, urt, br, we, ld, tk, mb, clr;
    logic [4:0] rs, rt, rd;
    logic       s, fd, fe;
    logic [1:0] fad, fbd, fae, fbe;
  } vec_t;

  typedef struct {
    int         row;
    logic       s, fd, fe;
    logic [1:0] fad, fbd, fae, fbe;
    logic [15:0] scnt, fcnt;
  } exp_t;

  vec_t tbl [23];
  exp_t sbq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic issue, urs, urt, br, we, ld, tk, mb, clr,
                              input int rs, rt, rd, input logic s, fd, fe,
                              input int fad, fbd, fae, fbe);
    vec_t v;
    v.issue = issue; v.urs = urs; v.urt = urt; v.br = br; v.we = we;
    v.ld = ld; v.tk = tk; v.mb = mb; v.clr = clr;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
    v.s = s; v.fd = fd; v.fe = fe;
    v.fad = 2'(fad); v.fbd = 2'(fbd); v.fae = 2'(fae); v.fbe = 2'(fbe);
    return v;
  endfunction

  task automatic a_drive(input vec_t v);
    a_issue = v.issue; a_urs = v.urs; a_urt = v.urt; a_br = v.br; a_we = v.we;
    a_ld = v.ld; a_tk = v.tk; a_mb = v.mb; a_clr = v.clr;
    a_rs = v.rs; a_rt = v.rt; a_rd = v.rd;
  endtask

  task automatic b_set(input logic issue, urs, urt, br, we, ld, tk, mb, clr,
                       input int rs, rt, rd);
    b_issue = issue; b_urs = urs; b_urt = urt; b_br = br; b_we = we;
    b_ld = ld; b_tk = tk; b_mb = mb; b_clr = clr;
    b_rs = 5'(rs); b_rt = 5'(rt); b_rd = 5'(rd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [15:0] m_s, m_f;
    int exp_b;

    // issue urs urt br we ld tk mb clr | rs rt rd | stall fd fe | fad fbd fae fbe
    tbl[0]  = mk(1,1,1,0,1,0,0,0,0, 1,2,3, 0,0,0, 0,0,0,0); // add r3
    tbl[1]  = mk(1,1,1,0,1,0,0,0,0, 4,5,3, 0,0,0, 0,0,0,0); // add r3 again
    tbl[2]  = mk(1,1,1,0,1,0,0,0,0, 3,3,7, 0,0,0, 0,0,0,0); // consumer of r3
    tbl[3]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,2,2); // nearest r3 wins
    tbl[4]  = mk(1,1,1,0,1,0,0,0,0, 1,2,0, 0,0,0, 0,0,0,0); // writes r0
    tbl[5]  = mk(1,1,1,0,1,0,0,0,0, 0,7,9, 0,0,0, 0,0,0,0); // reads r0, r7
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0); // r0 never forwards
    tbl[7]  = mk(1,1,0,0,1,1,0,0,0, 1,0,5, 0,0,0, 0,0,0,0); // load r5
    tbl[8]  = mk(1,1,1,0,1,0,0,0,0, 5,2,6, 0,0,0, 0,0,0,0); // use r5, LDSTG=2
    tbl[9]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,2,0); // load fwd from M
    tbl[10] = mk(1,1,1,0,1,0,0,0,0, 1,2,4, 0,0,0, 0,0,0,0); // ALU r4
    tbl[11] = mk(1,1,1,1,0,0,1,0,0, 4,0,0, 1,0,1, 0,0,0,0); // branch r4: stall
    tbl[12] = mk(1,1,1,1,0,0,1,0,0, 4,0,0, 0,1,0, 2,0,0,0); // fwd M, taken
    tbl[13] = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,3,0); // branch in E
    tbl[14] = mk(1,1,0,0,1,1,0,0,0, 1,0,8, 0,0,0, 0,0,0,0); // load r8
    tbl[15] = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    tbl[16] = mk(1,1,1,1,0,0,0,0,0, 8,0,0, 0,0,0, 2,0,0,0); // branch, load at M
    tbl[17] = mk(0,1,1,1,0,0,1,1,0, 8,0,0, 1,0,0, 3,0,3,0); // mem busy
    tbl[18] = mk(0,1,1,1,0,0,1,1,0, 8,0,0, 1,0,0, 3,0,3,0);
    tbl[19] = mk(0,1,1,1,0,0,1,1,0, 8,0,0, 1,0,0, 3,0,3,0);
    tbl[20] = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,3,0); // entries held
    tbl[21] = mk(0,0,0,0,0,0,0,0,1, 0,0,0, 0,0,0, 0,0,0,0); // clear counters
    tbl[22] = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);

    // Reset: StallF follows MemBusy, everything else quiet.
    a_mb = 1'b1;
    #1;
    a_rst = 1'b1;
    b_rst = 1'b1;
    #3;
    chk("rst_stall_mb1", a_stall, 1);
    chk("rst_flushd", a_fld, 0);
    chk("rst_flushe", a_fle, 0);
    chk("rst_fwdae", a_fae, 0);
    chk("rst_fwdad", a_fad, 0);
    chk("rst_scnt", a_scnt, 0);
    chk("rst_fcnt", a_fcnt, 0);
    a_mb = 1'b0;
    #1;
    chk("rst_stall_mb0", a_stall, 0);
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    next_cycle();

    // Table on instance A with a counter model and an expectation queue.
    m_s = '0;
    m_f = '0;
    for (int i = 0; i < 23; i++) begin
      a_drive(tbl[i]);
      e.row = i; e.s = tbl[i].s; e.fd = tbl[i].fd; e.fe = tbl[i].fe;
      e.fad = tbl[i].fad; e.fbd = tbl[i].fbd; e.fae = tbl[i].fae; e.fbe = tbl[i].fbe;
      e.scnt = m_s; e.fcnt = m_f;
      sbq.push_back(e);
      if (tbl[i].clr) begin
        m_s = '0;
        m_f = '0;
      end else begin
        if (tbl[i].s) m_s++;
        if (tbl[i].fd || tbl[i].fe) m_f++;
      end
      @(negedge clk);
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL r%0d queue: got empty expected entry", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("r%0d stallf", e.row), a_stall, e.s);
        chk($sformatf("r%0d flushd", e.row), a_fld, e.fd);
        chk($sformatf("r%0d flushe", e.row), a_fle, e.fe);
        chk($sformatf("r%0d fwdad", e.row), a_fad, e.fad);
        chk($sformatf("r%0d fwdbd", e.row), a_fbd, e.fbd);
        chk($sformatf("r%0d fwdae", e.row), a_fae, e.fae);
        chk($sformatf("r%0d fwdbe", e.row), a_fbe, e.fbe);
        chk($sformatf("r%0d stallcnt", e.row), a_scnt, e.scnt);
        chk($sformatf("r%0d flushcnt", e.row), a_fcnt, e.fcnt);
      end
      next_cycle();
    end
    a_drive(tbl[22]);

    // B: FlushCnt saturates at 3 over five redirects, then clears.
    for (int i = 0; i < 5; i++) begin
      b_set(0,0,0,0,0,0,1,0,0, 0,0,0);
      @(negedge clk);
      exp_b = (i < 3) ? i : 3;
      chk($sformatf("sat%0d flushd", i), b_fld, 1);
      chk($sformatf("sat%0d flushcnt", i), b_fcnt, exp_b);
      next_cycle();
    end
    b_set(0,0,0,0,0,0,1,0,1, 0,0,0);
    @(negedge clk);
    chk("sat_hold flushcnt", b_fcnt, 3);
    chk("clr_taken flushd", b_fld, 1);
    next_cycle();
    b_set(0,0,0,0,0,0,0,0,0, 0,0,0);
    @(negedge clk);
    chk("clr flushcnt", b_fcnt, 0);
    chk("clr stallcnt", b_scnt, 0);
    next_cycle();

    // B: load-use with LDSTG=4 stalls exactly two cycles.
    b_set(1,1,0,0,1,1,0,0,0, 1,0,5);
    @(negedge clk);
    chk("lu_load stallf", b_stall, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      b_set(1,1,0,0,1,0,0,0,0, 5,0,6);
      @(negedge clk);
      chk($sformatf("lu%0d stallf", i), b_stall, (i < 2) ? 1 : 0);
      chk($sformatf("lu%0d flushe", i), b_fle, (i < 2) ? 1 : 0);
      next_cycle();
    end
    b_set(0,0,0,0,0,0,0,0,0, 0,0,0);
    @(negedge clk);
    chk("lu_fwd fwdae", b_fae, 4);
    chk("lu stallcnt", b_scnt, 2);
    chk("lu flushcnt", b_fcnt, 2);
    next_cycle();

    // B: reset asserted in the middle of a load-use stall.
    b_set(1,1,0,0,1,0,0,0,0, 1,0,2);
    next_cycle();
    b_set(1,1,0,0,1,1,0,0,0, 2,0,5);
    next_cycle();
    b_set(1,1,0,0,1,0,0,0,0, 5,0,6);
    @(negedge clk);
    chk("pre_rst stallf", b_stall, 1);
    chk("pre_rst fwdae", b_fae, 2);
    #1;
    b_rst = 1'b1;
    #1;
    chk("mid_rst stallf", b_stall, 0);
    chk("mid_rst flushe", b_fle, 0);
    chk("mid_rst fwdae", b_fae, 0);
    chk("mid_rst fwdad", b_fad, 0);
    chk("mid_rst stallcnt", b_scnt, 0);
    chk("mid_rst flushcnt", b_fcnt, 0);
    next_cycle();
    b_rst = 1'b0;
    b_set(0,0,0,0,0,0,0,0,0, 0,0,0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
